uart_word_bridge: RTL

Parametrised bridge between a byte-wide UART link and a word-wide BRAM address space.
- **Load path:** packs received bytes into `WORD_BYTES`-wide words and writes them to sequential addresses, with explicit flush of partial words and overflow protection.
- **Dump path:** reads a selectable word range back and serialises it byte-by-byte into the UART transmitter, respecting BRAM read latency and transmitter busy.
- **Placement:** between `uart_receive` / `uart_transmit` and the memory regions in `top_level`. Region decode of `wr_addr_out` / `rd_addr_out` stays outside this block.

---
 rtl/uart_word_bridge_if.sv | 48 ++++
 rtl/uart_word_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_bridge_if.sv
// Signal bundle between uart_word_bridge and its UART receiver/transmitter and BRAM ports.
// The bridge uses the slave view; the surrounding logic (or a bench) uses the master view.
interface uart_word_bridge_if #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 25_250
);
  localparam int W  = 8 * WORD_BYTES;
  localparam int AW = $clog2(DEPTH);

  logic          rx_valid_in;
  logic [7:0]    rx_byte_in;
  logic          flush_in;
  logic          clear_in;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [W-1:0]  wr_data_out;
  logic [AW:0]   word_count_out;
  logic          full_out;
  logic          dump_start_in;
  logic [AW-1:0] dump_base_in;
  logic [AW:0]   dump_len_in;
  logic [AW-1:0] rd_addr_out;
  logic [W-1:0]  rd_data_in;
  logic [7:0]    tx_byte_out;
  logic          tx_trigger_out;
  logic          tx_busy_in;
  logic          dump_busy_out;
  logic          dump_done_out;
  logic [2:0]    dump_state_out;

  // Handshakes: rx_valid_in, wr_en_out and tx_trigger_out are one-cycle strobes with no ready
  // (the load path never stalls); a trigger is only issued in a cycle after tx_busy_in was low.
  modport slave (
    input  rx_valid_in, rx_byte_in, flush_in, clear_in,
    input  dump_start_in, dump_base_in, dump_len_in, rd_data_in, tx_busy_in,
    output wr_en_out, wr_addr_out, wr_data_out, word_count_out, full_out,
    output rd_addr_out, tx_byte_out, tx_trigger_out, dump_busy_out, dump_done_out,
    output dump_state_out
  );

  modport master (
    output rx_valid_in, rx_byte_in, flush_in, clear_in,
    output dump_start_in, dump_base_in, dump_len_in, rd_data_in, tx_busy_in,
    input  wr_en_out, wr_addr_out, wr_data_out, word_count_out, full_out,
    input  rd_addr_out, tx_byte_out, tx_trigger_out, dump_busy_out, dump_done_out,
    input  dump_state_out
  );
endinterface

// File: rtl/uart_word_bridge.sv
// Byte-stream <-> word-memory bridge: packs UART bytes into BRAM words and dumps a word
// range back out through the UART transmitter. Load and dump paths run independently.
module uart_word_bridge #(
  parameter int WORD_BYTES   = 4,
  parameter int DEPTH        = 25_250,
  parameter int READ_LATENCY = 2,
  parameter int MSB_FIRST    = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  uart_word_bridge_if.slave bus
);
  localparam int W  = 8 * WORD_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int KW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(WORD_BYTES - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_WORD   = (AW+1)'(1);
  localparam logic [2:0]    LAT_LAST   = 3'(READ_LATENCY);

  // Bit offset of byte slot idx inside a word; shared by packing and serialising.
  function automatic int slot_lsb(input logic [KW-1:0] idx);
    return (MSB_FIRST != 0) ? 8 * (WORD_BYTES - 1 - int'(idx)) : 8 * int'(idx);
  endfunction

  // ---------------- load path ----------------
  logic [W-1:0]  pack_q, pack_n, packed_w;
  logic [KW-1:0] k_q, k_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [AW:0]   count_q, count_n;
  logic          wr_en_q, wr_en_n;
  logic [AW-1:0] wr_addr_q, wr_addr_n;
  logic [W-1:0]  wr_data_q, wr_data_n;
  logic          full, complete, pending;

  assign full = (count_q == COUNT_FULL);

  always_comb begin
    packed_w  = pack_q;
    complete  = 1'b0;
    pending   = (k_q != '0);
    pack_n    = pack_q;
    k_n       = k_q;
    addr_n    = addr_q;
    count_n   = count_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    if (bus.clear_in) begin
      pack_n  = '0;
      k_n     = '0;
      addr_n  = '0;
      count_n = '0;
    end else begin
      // The byte is absorbed before a same-cycle flush decides whether to write.
      if (bus.rx_valid_in) begin
        packed_w[slot_lsb(k_q) +: 8] = bus.rx_byte_in;
        complete = (k_q == K_LAST);
        pending  = 1'b1;
      end
      if (complete || (bus.flush_in && pending)) begin
        pack_n = '0;
        k_n    = '0;
        if (!full) begin
          wr_en_n   = 1'b1;
          wr_addr_n = addr_q;
          wr_data_n = packed_w;
          addr_n    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
          count_n   = count_q + 1'b1;
        end
      end else if (bus.rx_valid_in) begin
        pack_n = packed_w;
        k_n    = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pack_q    <= '0;
      k_q       <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      pack_q    <= pack_n;
      k_q       <= k_n;
      addr_q    <= addr_n;
      count_q   <= count_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end

  assign bus.wr_en_out      = wr_en_q;
  assign bus.wr_addr_out    = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign bus.word_count_out = count_q;
  assign bus.full_out       = full;

  // ---------------- dump path ----------------
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_GUARD, S_WAIT, S_DONE
  } dump_state_t;

  dump_state_t   state_q, state_n;
  logic [AW-1:0] rd_addr_q, rd_addr_n;
  logic [AW:0]   left_q, left_n;
  logic [2:0]    lat_q, lat_n;
  logic [W-1:0]  shift_q, shift_n;
  logic [KW-1:0] j_q, j_n;
  logic [7:0]    tx_byte_q, tx_byte_n;
  logic          tx_trig_q, tx_trig_n;

  always_comb begin
    state_n   = state_q;
    rd_addr_n = rd_addr_q;
    left_n    = left_q;
    lat_n     = lat_q;
    shift_n   = shift_q;
    j_n       = j_q;
    tx_byte_n = tx_byte_q;
    tx_trig_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dump_start_in) begin
          if (bus.dump_len_in == '0) begin
            state_n = S_DONE;
          end else begin
            rd_addr_n = bus.dump_base_in;
            left_n    = bus.dump_len_in;
            lat_n     = '0;
            state_n   = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (lat_q == LAT_LAST) begin
          shift_n = bus.rd_data_in;
          j_n     = '0;
          state_n = S_SEND;
        end else begin
          lat_n = lat_q + 1'b1;
        end
      end
      S_SEND: begin
        if (!bus.tx_busy_in) begin
          tx_byte_n = shift_q[slot_lsb(j_q) +: 8];
          tx_trig_n = 1'b1;
          state_n   = S_GUARD;
        end
      end
      // Gives the transmitter a cycle to raise busy before it is looked at again.
      S_GUARD: state_n = S_WAIT;
      S_WAIT: begin
        if (!bus.tx_busy_in) begin
          if (j_q != K_LAST) begin
            j_n     = j_q + 1'b1;
            state_n = S_SEND;
          end else if (left_q != ONE_WORD) begin
            left_n    = left_q - 1'b1;
            rd_addr_n = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + 1'b1;
            lat_n     = '0;
            state_n   = S_FETCH;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      left_q    <= '0;
      lat_q     <= '0;
      shift_q   <= '0;
      j_q       <= '0;
      tx_byte_q <= '0;
      tx_trig_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      rd_addr_q <= rd_addr_n;
      left_q    <= left_n;
      lat_q     <= lat_n;
      shift_q   <= shift_n;
      j_q       <= j_n;
      tx_byte_q <= tx_byte_n;
      tx_trig_q <= tx_trig_n;
    end
  end

  assign bus.rd_addr_out    = rd_addr_q;
  assign bus.tx_byte_out    = tx_byte_q;
  assign bus.tx_trigger_out = tx_trig_q;
  assign bus.dump_busy_out  = (state_q != S_IDLE);
  assign bus.dump_done_out  = (state_q == S_DONE);
  assign bus.dump_state_out = state_q;
endmodule
